// File: rtl/alu_and_bist.sv
// rtl/alu_and_bist.sv - walking-ones/zeros BIST engine for the ALU AND unit
//
// Drives thermometer operand pairs onto op_a/op_b, waits SETTLE_CYCLES, then
// compares dut_result against op_a & op_b. Accumulates a saturating error
// count and captures the first failing vector.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 begin a run (honoured only in IDLE or DONE)
//   dut_result            AND unit output under test
//   op_a, op_b            registered operands to the AND unit
//   busy, done, pass      run status; pass is meaningful while done is high
//   err_count             saturating mismatch count
//   fail_valid            first-failure capture is populated
//   fail_a/fail_b/fail_result  operands and observed result of first mismatch

module alu_and_bist #(
    parameter int DATA_WIDTH    = 64,
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dut_result,
    output logic [DATA_WIDTH-1:0] op_a,
    output logic [DATA_WIDTH-1:0] op_b,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic                  fail_valid,
    output logic [DATA_WIDTH-1:0] fail_a,
    output logic [DATA_WIDTH-1:0] fail_b,
    output logic [DATA_WIDTH-1:0] fail_result
);

    localparam int IW = $clog2(DATA_WIDTH);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  phase_q, phase_d;
    logic [IW-1:0]         i_q, i_d;
    logic [IW-1:0]         j_q, j_d;
    logic [SW-1:0]         s_q, s_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
    logic [ERR_WIDTH-1:0]  err_q, err_d;
    logic                  fail_valid_q, fail_valid_d;
    logic [DATA_WIDTH-1:0] fail_a_q, fail_a_d;
    logic [DATA_WIDTH-1:0] fail_b_q, fail_b_d;
    logic [DATA_WIDTH-1:0] fail_result_q, fail_result_d;

    // Low k+1 bits set. The shift amount is one bit wider than k so that
    // k = DATA_WIDTH-1 shifts everything out, leaving an all-ones mask.
    function automatic logic [DATA_WIDTH-1:0] mask(input logic [IW-1:0] k);
        logic [IW:0] sh;
        sh   = {1'b0, k} + 1'b1;
        mask = ~({DATA_WIDTH{1'b1}} << sh);
    endfunction

    logic          j_last, i_last, mismatch;
    logic          ni_phase;
    logic [IW-1:0] ni, nj;

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        i_d           = i_q;
        j_d           = j_q;
        s_d           = s_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        err_d         = err_q;
        fail_valid_d  = fail_valid_q;
        fail_a_d      = fail_a_q;
        fail_b_d      = fail_b_q;
        fail_result_d = fail_result_q;

        j_last   = (j_q == IW'(DATA_WIDTH - 1));
        i_last   = (i_q == IW'(DATA_WIDTH - 1));
        mismatch = (dut_result != (op_a_q & op_b_q));
        nj       = j_last ? '0 : j_q + 1'b1;
        ni       = j_last ? (i_last ? '0 : i_q + 1'b1) : i_q;
        ni_phase = (j_last && i_last) ? 1'b1 : phase_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    err_d         = '0;
                    fail_valid_d  = 1'b0;
                    fail_a_d      = '0;
                    fail_b_d      = '0;
                    fail_result_d = '0;
                    phase_d       = 1'b0;
                    i_d           = '0;
                    j_d           = '0;
                    s_d           = '0;
                    op_a_d        = mask('0);
                    op_b_d        = mask('0);
                    state_d       = ST_APPLY;
                end
            end
            ST_APPLY: begin
                s_d = s_q + 1'b1;
                if (s_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    if (err_q != {ERR_WIDTH{1'b1}}) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!fail_valid_q) begin
                        fail_valid_d  = 1'b1;
                        fail_a_d      = op_a_q;
                        fail_b_d      = op_b_q;
                        fail_result_d = dut_result;
                    end
                end
                if (phase_q && i_last && j_last) begin
                    // Operands stay on the last (all-zeros) vector in DONE.
                    state_d = ST_DONE;
                end else begin
                    phase_d = ni_phase;
                    i_d     = ni;
                    j_d     = nj;
                    s_d     = '0;
                    op_a_d  = ni_phase ? ~mask(ni) : mask(ni);
                    op_b_d  = ni_phase ? ~mask(nj) : mask(nj);
                    state_d = ST_APPLY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            phase_q       <= 1'b0;
            i_q           <= '0;
            j_q           <= '0;
            s_q           <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            err_q         <= '0;
            fail_valid_q  <= 1'b0;
            fail_a_q      <= '0;
            fail_b_q      <= '0;
            fail_result_q <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            i_q           <= i_d;
            j_q           <= j_d;
            s_q           <= s_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            err_q         <= err_d;
            fail_valid_q  <= fail_valid_d;
            fail_a_q      <= fail_a_d;
            fail_b_q      <= fail_b_d;
            fail_result_q <= fail_result_d;
        end
    end

    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign busy        = (state_q == ST_APPLY) || (state_q == ST_CHECK);
    assign done        = (state_q == ST_DONE);
    assign pass        = done && (err_q == '0);
    assign err_count   = err_q;
    assign fail_valid  = fail_valid_q;
    assign fail_a      = fail_a_q;
    assign fail_b      = fail_b_q;
    assign fail_result = fail_result_q;

endmodule
